// File: rtl/conv_pkg.sv
// Shared constants and FSM state encoding for the 3x3 convolution window reader.
package conv_pkg;

    localparam int CONV_WIDTH     = 8;
    localparam int CONV_ADDR_BIT  = 5;
    localparam int CONV_ACC_WIDTH = 2 * CONV_WIDTH + 4;
    localparam int CONV_TAPS      = 9;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_WAIT_LOAD = 3'd1,
        ST_RUN       = 3'd2,
        ST_DRAIN     = 3'd3,
        ST_DONE      = 3'd4
    } conv_state_e;

    // Nine 2*w-bit products need four guard bits for an exact sum.
    function automatic int acc_width(input int w);
        return 2 * w + 4;
    endfunction

endpackage

// File: rtl/conv_mac9.sv
// Three-stage 3x3 multiply-accumulate: window register, nine products, exact sum.
// Define CONV_RELU_EN to clamp negative sums to zero in the final stage.
module conv_mac9 import conv_pkg::*; #(
    parameter int WIDTH     = CONV_WIDTH,
    parameter int ACC_WIDTH = acc_width(WIDTH)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    input  logic                 in_last,
    input  logic [9*WIDTH-1:0]   kernel,
    input  logic [9*WIDTH-1:0]   window,
    output logic [ACC_WIDTH-1:0] res,
    output logic                 res_valid,
    output logic                 res_last,
    output logic                 pipe_busy
);

    localparam int PW = 2 * WIDTH;

    logic [9*WIDTH-1:0]          win_q, win_d;
    logic                        v1_q, v1_d, l1_q, l1_d;
    logic                        v2_q, v2_d, l2_q, l2_d;
    logic                        v3_q, v3_d, l3_q, l3_d;
    logic signed [PW-1:0]        prod_q [CONV_TAPS];
    logic signed [PW-1:0]        prod_d [CONV_TAPS];
    logic signed [ACC_WIDTH-1:0] sum;
    logic signed [ACC_WIDTH-1:0] sum_final;
    logic [ACC_WIDTH-1:0]        res_q, res_d;

    generate
        for (genvar gi = 0; gi < CONV_TAPS; gi++) begin : g_tap
            assign prod_d[gi] = PW'($signed(win_q[gi*WIDTH +: WIDTH]))
                              * PW'($signed(kernel[gi*WIDTH +: WIDTH]));
        end
    endgenerate

    always_comb begin
        sum = '0;
        for (int i = 0; i < CONV_TAPS; i++) begin
            sum = sum + ACC_WIDTH'(prod_q[i]);
        end
    end

`ifdef CONV_RELU_EN
    assign sum_final = sum[ACC_WIDTH-1] ? '0 : sum;
`else
    assign sum_final = sum;
`endif

    always_comb begin
        win_d = window;
        v1_d  = in_valid;
        l1_d  = in_valid & in_last;
        v2_d  = v1_q;
        l2_d  = l1_q;
        v3_d  = v2_q;
        l3_d  = l2_q;
        // Result register only moves on a valid sum so res holds between results.
        res_d = res_q;
        if (v2_q) begin
            res_d = sum_final;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            win_q <= '0;
            v1_q  <= 1'b0;
            l1_q  <= 1'b0;
            v2_q  <= 1'b0;
            l2_q  <= 1'b0;
            v3_q  <= 1'b0;
            l3_q  <= 1'b0;
            res_q <= '0;
            for (int i = 0; i < CONV_TAPS; i++) begin
                prod_q[i] <= '0;
            end
        end else begin
            win_q <= win_d;
            v1_q  <= v1_d;
            l1_q  <= l1_d;
            v2_q  <= v2_d;
            l2_q  <= l2_d;
            v3_q  <= v3_d;
            l3_q  <= l3_d;
            res_q <= res_d;
            for (int i = 0; i < CONV_TAPS; i++) begin
                prod_q[i] <= prod_d[i];
            end
        end
    end

    assign res       = res_q;
    assign res_valid = v3_q;
    assign res_last  = v3_q & l3_q;
    // Stage 3 is being presented this cycle, so only stages 1-2 count as in flight.
    assign pipe_busy = v1_q | v2_q;

endmodule

// File: rtl/conv_window_reader.sv
// Frame sequencer that pops 3x3 windows from a line-buffer FIFO and feeds conv_mac9.
// Optional CONV_RELU_EN clamps negative results to zero (no extra latency).
module conv_window_reader import conv_pkg::*; #(
    parameter int WIDTH     = CONV_WIDTH,
    parameter int ADDR_BIT  = CONV_ADDR_BIT,
    parameter int ACC_WIDTH = acc_width(WIDTH)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [ADDR_BIT-1:0]  row_len,
    input  logic [ADDR_BIT-1:0]  row_cnt,
    input  logic [9*WIDTH-1:0]   kernel,
    input  logic [3*WIDTH-1:0]   out2,
    input  logic [3*WIDTH-1:0]   out1,
    input  logic [3*WIDTH-1:0]   out0,
    input  logic                 load_done,
    input  logic                 empty,
    output logic                 ren,
    output logic [ACC_WIDTH-1:0] res,
    output logic                 res_valid,
    output logic                 res_last,
    output logic                 busy,
    output logic                 done
);

    conv_state_e         state_q, state_d;
    logic [ADDR_BIT-1:0] col_q, col_d;
    logic [ADDR_BIT-1:0] row_q, row_d;
    logic [ADDR_BIT-1:0] row_len_q, row_len_d;
    logic [ADDR_BIT-1:0] row_cnt_q, row_cnt_d;
    logic [9*WIDTH-1:0]  kernel_q, kernel_d;

    logic last_col;
    logic last_row;
    logic col_valid;
    logic pipe_busy;

    assign last_col  = (col_q == row_len_q - ADDR_BIT'(1));
    assign last_row  = (row_q == row_cnt_q - ADDR_BIT'(3));
    assign col_valid = (col_q >= ADDR_BIT'(2));

    always_comb begin
        state_d   = state_q;
        col_d     = col_q;
        row_d     = row_q;
        row_len_d = row_len_q;
        row_cnt_d = row_cnt_q;
        kernel_d  = kernel_q;
        ren       = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    row_len_d = row_len;
                    row_cnt_d = row_cnt;
                    kernel_d  = kernel;
                    col_d     = '0;
                    row_d     = '0;
                    // Frames smaller than one kernel produce no windows at all.
                    if (row_len < ADDR_BIT'(3) || row_cnt < ADDR_BIT'(3)) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_WAIT_LOAD;
                    end
                end
            end
            ST_WAIT_LOAD: begin
                busy = 1'b1;
                if (load_done) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                busy = 1'b1;
                ren  = !empty;
                if (ren) begin
                    if (last_col) begin
                        col_d = '0;
                        if (last_row) begin
                            state_d = ST_DRAIN;
                        end else begin
                            row_d = row_q + ADDR_BIT'(1);
                        end
                    end else begin
                        col_d = col_q + ADDR_BIT'(1);
                    end
                end
            end
            ST_DRAIN: begin
                busy = 1'b1;
                if (!pipe_busy) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                done    = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            col_q     <= '0;
            row_q     <= '0;
            row_len_q <= '0;
            row_cnt_q <= '0;
            kernel_q  <= '0;
        end else begin
            state_q   <= state_d;
            col_q     <= col_d;
            row_q     <= row_d;
            row_len_q <= row_len_d;
            row_cnt_q <= row_cnt_d;
            kernel_q  <= kernel_d;
        end
    end

    conv_mac9 #(
        .WIDTH     (WIDTH),
        .ACC_WIDTH (ACC_WIDTH)
    ) u_mac9 (
        .clk       (clk),
        .rst_n     (rst),
        .in_valid  (ren & col_valid),
        .in_last   (ren & last_col & last_row),
        .kernel    (kernel_q),
        .window    ({out2, out1, out0}),
        .res       (res),
        .res_valid (res_valid),
        .res_last  (res_last),
        .pipe_busy (pipe_busy)
    );

endmodule
